// File: rtl/serial_frame_receiver_if.sv
// Bus bundle for the serial frame receiver: serial line, bit strobe, order select
// and the parallel valid/ready output with status pulses.
interface serial_frame_receiver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             Ser_in;
  logic             Bit_en;
  logic             Dir;
  logic [WIDTH-1:0] P_out;
  logic             Out_valid;
  logic             Out_ready;
  logic             Busy;
  logic             Frame_err;
  logic             Overrun;

  modport slave (
    input  Ser_in, Bit_en, Dir, Out_ready,
    output P_out, Out_valid, Busy, Frame_err, Overrun
  );

  modport master (
    output Ser_in, Bit_en, Dir, Out_ready,
    input  P_out, Out_valid, Busy, Frame_err, Overrun
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// Framed serial receiver: start bit, WIDTH data bits in latched bit order, stop bit,
// then a held valid/ready word with one-cycle framing-error and overrun pulses.
module serial_frame_receiver #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  serial_frame_receiver_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;

  state_t           r_state, w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sreg, r_pout;
  logic             r_dir, r_valid, r_ferr, r_ovr;
  logic             w_last, w_start, w_shift, w_commit, w_bad_stop, w_accept, w_busy;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.Bit_en) begin
      case (r_state)
        IDLE:    if (!bus.Ser_in) w_next_state = DATA;
        DATA:    if (w_last) w_next_state = STOP;
        STOP:    w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy     = (r_state != IDLE);
    w_start    = bus.Bit_en && (r_state == IDLE) && !bus.Ser_in;
    w_shift    = bus.Bit_en && (r_state == DATA);
    w_commit   = bus.Bit_en && (r_state == STOP) && bus.Ser_in;
    w_bad_stop = bus.Bit_en && (r_state == STOP) && !bus.Ser_in;
    w_accept   = r_valid && bus.Out_ready;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_dir   <= 1'b0;
      r_pout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_bad_stop;
      r_ovr  <= 1'b0;
      if (w_start) begin
        r_cnt <= '0;
        r_dir <= bus.Dir;
      end
      if (w_shift) begin
        if (!w_last) r_cnt <= r_cnt + CW'(1);
        if (r_dir) r_sreg <= {r_sreg[WIDTH-2:0], bus.Ser_in};
        else       r_sreg <= {bus.Ser_in, r_sreg[WIDTH-1:1]};
      end
      // A commit wins over an accept on the same edge; only an unaccepted word overruns.
      if (w_commit) begin
        r_pout  <= r_sreg;
        r_valid <= 1'b1;
        r_ovr   <= r_valid && !bus.Out_ready;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.P_out     = r_pout;
  assign bus.Out_valid = r_valid;
  assign bus.Busy      = w_busy;
  assign bus.Frame_err = r_ferr;
  assign bus.Overrun   = r_ovr;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Randomized bench for serial_frame_receiver: frames are built from words and compared
// against a transaction-level model of the output handshake.
module tb_serial_frame_receiver;
  localparam int unsigned W = 4;
  localparam int EV_NONE = 0, EV_START = 1, EV_GOOD = 2, EV_BAD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_frame_receiver_if #(.WIDTH(W)) bus ();
  serial_frame_receiver #(.WIDTH(W)) dut (.Clk(clk), .Rst(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  logic         m_valid, m_busy, m_ferr, m_ovr;
  logic [W-1:0] m_pout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"}, 32'(bus.Out_valid), 32'(m_valid));
    check_eq({tag, ".p_out"}, 32'(bus.P_out), 32'(m_pout));
    check_eq({tag, ".busy"}, 32'(bus.Busy), 32'(m_busy));
    check_eq({tag, ".frame_err"}, 32'(bus.Frame_err), 32'(m_ferr));
    check_eq({tag, ".overrun"}, 32'(bus.Overrun), 32'(m_ovr));
  endtask

  // One clock: drive at negedge, predict post-edge outputs, sample 1 time unit after posedge.
  task automatic step(input logic ser, input logic en, input logic dir, input logic rdy,
                      input int ev, input logic [W-1:0] word);
    bus.Ser_in    = ser;
    bus.Bit_en    = en;
    bus.Dir       = dir;
    bus.Out_ready = rdy;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (en && ev == EV_GOOD) begin
      m_ovr   = m_valid && !rdy;
      m_valid = 1'b1;
      m_pout  = word;
      m_busy  = 1'b0;
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (en && ev == EV_BAD) begin
        m_ferr = 1'b1;
        m_busy = 1'b0;
      end
      if (en && ev == EV_START) m_busy = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all("cyc");
    @(negedge clk);
  endtask

  // mode: 0 random ready, 1 never ready, 2 always ready, 3 ready only on the stop strobe
  function automatic logic pick_rdy(input int mode, input bit is_stop);
    case (mode)
      0:       return logic'($urandom_range(0, 1));
      1:       return 1'b0;
      2:       return 1'b1;
      default: return logic'(is_stop);
    endcase
  endfunction

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b1, logic'($urandom_range(0, 1)), pick_rdy(mode, 1'b0), EV_NONE, '0);
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic dir, input bit good,
                            input int period, input int mode, input bit wobble);
    for (int k = 0; k < int'(W) + 2; k++) begin
      logic b, d;
      int   ev;
      bit   is_stop;
      is_stop = (k == int'(W) + 1);
      if (k == 0) begin
        b = 1'b0; ev = EV_START;
      end else if (is_stop) begin
        b = logic'(good); ev = good ? EV_GOOD : EV_BAD;
      end else begin
        b  = dir ? word[int'(W) - k] : word[k - 1];
        ev = EV_NONE;
      end
      for (int g = 1; g < period; g++)
        step(logic'($urandom_range(0, 1)), 1'b0, logic'($urandom_range(0, 1)),
             pick_rdy(mode, 1'b0), EV_NONE, word);
      d = (k == 0 || !wobble) ? dir : logic'($urandom_range(0, 1));
      step(b, 1'b1, d, pick_rdy(mode, is_stop), ev, word);
    end
  endtask

  initial begin
    bus.Ser_in = 1'b1; bus.Bit_en = 1'b0; bus.Dir = 1'b0; bus.Out_ready = 1'b0;
    m_valid = 1'b0; m_busy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_pout = '0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    idle(3, 2);

    // LSB-first 0xB
    send_frame(4'hB, 1'b0, 1'b1, 1, 1, 1'b0);

    // Reset in the middle of DATA clears everything immediately
    step(1'b0, 1'b1, 1'b0, 1'b0, EV_START, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, EV_NONE, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, EV_NONE, '0);
    #2 rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_busy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_pout = '0;
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, 0);

    // MSB-first 0xB, then a single accept cycle
    send_frame(4'hB, 1'b1, 1'b1, 1, 1, 1'b0);
    idle(1, 2);
    idle(1, 1);

    // Bad stop bit, then a good 0x5
    send_frame(4'hF, 1'b0, 1'b0, 1, 1, 1'b0);
    send_frame(4'h5, 1'b0, 1'b1, 1, 1, 1'b0);
    idle(1, 2);

    // Overrun on unaccepted word; then commit coinciding with accept
    send_frame(4'h3, 1'b0, 1'b1, 1, 1, 1'b0);
    send_frame(4'hC, 1'b0, 1'b1, 1, 1, 1'b0);
    idle(2, 1);
    send_frame(4'h3, 1'b1, 1'b1, 1, 2, 1'b0);
    send_frame(4'h3, 1'b1, 1'b1, 1, 1, 1'b0);
    send_frame(4'hC, 1'b1, 1'b1, 1, 3, 1'b0);
    idle(1, 2);

    // Sparse strobes with Dir wobbling after the start bit
    for (int i = 0; i < 4; i++)
      send_frame(W'($urandom), logic'(i % 2), 1'b1, 3, 0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      send_frame(W'($urandom), logic'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                 $urandom_range(1, 3), 0, 1'b1);
      idle($urandom_range(0, 2), 0);
    end
    idle(3, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
